accum_cpu: RTL and testbench

Synthesizable, parametrised accumulator CPU core: two-word instruction fetch, a decode/execute state machine, and a single synchronous memory port. It replaces the behavioural fetch/execute loop in the CPU testbench with a real core. Memory is preloaded through a separate port while the core idles; the core starts when `run` is asserted. It adds distinct AND/OR/NOT opcodes, JNS/JUMPI (subroutine call/return), signed skip conditions and illegal-opcode trapping.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/alu_param.sv | 30 +++
 rtl/single_port_sync_ram_large.sv | 32 +++
 rtl/accum_cpu.sv | 190 +++++++++++++++++++
 tb/tb_accum_cpu.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the accumulator CPU core.
//   opcode_e    : 4-bit opcode field of instruction word 0
//   SKIP_*      : skip-condition codes (instruction word 0, bits [1:0])
//   ALU_*       : mode codes understood by alu_param
//   state_e     : fetch/execute state machine encoding
//   is_mem_read : opcodes that read M[X] in EX0 and finish in EX2
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_HALT  = 4'h7,
    OP_SKIP  = 4'h8,
    OP_JUMP  = 4'h9,
    OP_CLEAR = 4'hA,
    OP_NOT   = 4'hB,
    OP_JUMPI = 4'hC,
    OP_JNS   = 4'hD,
    OP_ILL_E = 4'hE,
    OP_ILL_F = 4'hF
  } opcode_e;

  localparam logic [1:0] SKIP_NEG   = 2'b00;  // AC < 0 (signed)
  localparam logic [1:0] SKIP_ZERO  = 2'b01;  // AC == 0
  localparam logic [1:0] SKIP_POS   = 2'b10;  // AC > 0 (signed)
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE, S_IF0, S_IF1, S_IF2, S_IF3, S_EX0, S_EX1, S_EX2, S_HALT
  } state_e;

  function automatic logic is_mem_read(input opcode_e op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JUMPI};
  endfunction

endpackage

// File: rtl/alu_param.sv
// alu_param: combinational ALU for the accumulator core.
//   a       : accumulator operand
//   b       : memory operand (MBR)
//   aluMode : operation select (ALU_* codes in cpu_pkg)
//   s       : result, wraps modulo 2^DATA_WIDTH
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            aluMode,
  output logic [DATA_WIDTH-1:0] s
);

  // NOTE: every output of an always_comb block gets a value on every path
  // (here via the default arm); a missing assignment infers a latch.
  always_comb begin
    case (aluMode)
      ALU_ADD: s = a + b;
      ALU_SUB: s = a - b;
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_NOT: s = ~a;
      default: s = a;
    endcase
  end

endmodule

// File: rtl/single_port_sync_ram_large.sv
// single_port_sync_ram_large: single-port synchronous RAM shared by the
// program loader and the core.
//   clk   : clock
//   addr  : word address
//   cs    : access strobe; a read returns data on rdata the next cycle
//   we    : write enable, qualified by cs
//   wdata : write data
//   rdata : registered read data
module single_port_sync_ram_large #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cs,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // NOTE: the storage array has no reset; resetting a memory turns it into
  // flops. Contents are defined by the loader before the core runs.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/accum_cpu.sv
// accum_cpu: accumulator CPU core with two-word fetch and one synchronous
// memory port.
//   clk, rst  : clock, synchronous active-high reset
//   run       : start request, honoured only in IDLE
//   mem_*     : memory port (cs strobe, we write enable, rdata one cycle
//               after a read strobe)
//   pc, ac    : program counter and accumulator (debug)
//   halted    : core sits in HALT
//   illegal   : HALT was reached through opcode E or F
module accum_cpu
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  illegal
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PC_TWO = 2;

  state_e                  state;
  opcode_e                 ir_op;
  logic [1:0]              ir_cond;
  logic [ADDR_WIDTH-1:0]   ir_x;
  logic [DATA_WIDTH-1:0]   mbr;
  logic                    cs_q, we_q;

  logic [3:0]              alu_mode;
  logic [DATA_WIDTH-1:0]   alu_s;
  logic                    skip_taken;
  logic [ADDR_WIDTH-1:0]   pc_inc, ex0_pc, ex2_pc, fetch_x;
  opcode_e                 fetch_op;

  alu_param #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a       (ac),
    .b       (mbr),
    .aluMode (alu_mode),
    .s       (alu_s)
  );

  assign fetch_op = opcode_e'(mem_rdata[DATA_WIDTH-1 -: 4]);
  assign fetch_x  = mem_rdata[ADDR_WIDTH-1:0];
  assign pc_inc   = pc + PC_ONE;
  assign ex2_pc   = (ir_op == OP_JUMPI) ? mbr[ADDR_WIDTH-1:0] : pc;

  always_comb begin
    case (ir_op)
      OP_ADD:  alu_mode = ALU_ADD;
      OP_SUB:  alu_mode = ALU_SUB;
      OP_AND:  alu_mode = ALU_AND;
      OP_OR:   alu_mode = ALU_OR;
      default: alu_mode = ALU_NOT;
    endcase
  end

  always_comb begin
    skip_taken = 1'b0;
    case (ir_cond)
      SKIP_NEG:  skip_taken = ac[DATA_WIDTH-1];
      SKIP_ZERO: skip_taken = (ac == '0);
      SKIP_POS:  skip_taken = !ac[DATA_WIDTH-1] && (ac != '0);
      default:   skip_taken = 1'b0;
    endcase
  end

  // PC for the single-cycle instructions that return to IF0 from EX0.
  always_comb begin
    ex0_pc = pc;
    case (ir_op)
      OP_SKIP: if (skip_taken) ex0_pc = pc + PC_TWO;
      OP_JUMP: ex0_pc = ir_x;
      OP_JNS:  ex0_pc = ir_x + PC_ONE;
      default: ex0_pc = pc;
    endcase
  end

  // The memory strobes are registered, so each one is set on the edge that
  // enters the state owning it. The EX0 access is therefore decoded in IF3,
  // with the operand still on mem_rdata.
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ac        <= '0;
      mbr       <= '0;
      ir_op     <= OP_NOP;
      ir_cond   <= '0;
      ir_x      <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      cs_q <= 1'b0;
      we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_IF0;
            cs_q     <= 1'b1;
            mem_addr <= pc;
          end
        end
        S_IF0: state <= S_IF1;
        S_IF1: begin
          ir_op    <= fetch_op;
          ir_cond  <= mem_rdata[1:0];
          pc       <= pc_inc;
          cs_q     <= 1'b1;
          mem_addr <= pc_inc;
          state    <= S_IF2;
        end
        S_IF2: state <= S_IF3;
        S_IF3: begin
          ir_x  <= fetch_x;
          pc    <= pc_inc;
          state <= S_EX0;
          if (is_mem_read(ir_op)) begin
            cs_q     <= 1'b1;
            mem_addr <= fetch_x;
          end else if (ir_op == OP_STORE) begin
            cs_q      <= 1'b1;
            we_q      <= 1'b1;
            mem_addr  <= fetch_x;
            mem_wdata <= ac;
          end else if (ir_op == OP_JNS) begin
            // Return address is the instruction after the JNS.
            cs_q      <= 1'b1;
            we_q      <= 1'b1;
            mem_addr  <= fetch_x;
            mem_wdata <= DATA_WIDTH'(pc_inc);
          end
        end
        S_EX0: begin
          if (is_mem_read(ir_op)) begin
            state <= S_EX1;
          end else if (ir_op inside {OP_HALT, OP_ILL_E, OP_ILL_F}) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= (ir_op != OP_HALT);
          end else begin
            if (ir_op == OP_CLEAR)    ac <= '0;
            else if (ir_op == OP_NOT) ac <= alu_s;
            pc       <= ex0_pc;
            cs_q     <= 1'b1;
            mem_addr <= ex0_pc;
            state    <= S_IF0;
          end
        end
        S_EX1: begin
          mbr   <= mem_rdata;
          state <= S_EX2;
        end
        S_EX2: begin
          if (ir_op == OP_LOAD)       ac <= mbr;
          else if (ir_op != OP_JUMPI) ac <= alu_s;
          pc       <= ex2_pc;
          cs_q     <= 1'b1;
          mem_addr <= ex2_pc;
          state    <= S_IF0;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset must also suppress an access already strobed for this cycle, so
  // an aborted STORE never reaches memory.
  assign mem_cs = cs_q & ~rst;
  assign mem_we = we_q & ~rst;

endmodule

// File: tb/tb_accum_cpu.sv
// tb_accum_cpu: self-checking bench for accum_cpu plus shared RAM.
// An instruction-level interpreter predicts every memory write, the final
// PC/AC/illegal state and the run length in cycles; a monitor compares the
// core's writes against the predicted queue as they occur.
module tb_accum_cpu;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run;
  logic [AW-1:0] core_addr, pc;
  logic          core_cs, core_we, halted, illegal;
  logic [DW-1:0] core_wdata, ac, ram_rdata;

  logic          tb_sel, tb_cs, tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_wdata;

  logic [AW-1:0] ram_addr;
  logic          ram_cs, ram_we;
  logic [DW-1:0] ram_wdata;
  assign ram_addr  = tb_sel ? tb_addr  : core_addr;
  assign ram_cs    = tb_sel ? tb_cs    : core_cs;
  assign ram_we    = tb_sel ? tb_we    : core_we;
  assign ram_wdata = tb_sel ? tb_wdata : core_wdata;

  accum_cpu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_addr  (core_addr),
    .mem_cs    (core_cs),
    .mem_we    (core_we),
    .mem_wdata (core_wdata),
    .mem_rdata (ram_rdata),
    .pc        (pc),
    .ac        (ac),
    .halted    (halted),
    .illegal   (illegal)
  );

  single_port_sync_ram_large #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .cs    (ram_cs),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        q[$];
  logic [7:0] img [256];
  logic [7:0] mm  [256];
  logic [7:0] exp_pc, exp_ac;
  logic       exp_ill;
  int         exp_cyc;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         sb_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each core write must match the next predicted one.
  always @(negedge clk) begin
    if (sb_en && core_cs && core_we) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write",
                 core_addr, core_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_addr", core_addr, e.addr);
        check("wr_data", core_wdata, e.data);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [7:0] a, input logic [3:0] op, input logic [1:0] cond,
                     input logic [7:0] arg);
    logic [7:0] a1;
    a1 = a + 8'd1;
    img[a]  = {op, 2'b00, cond};
    img[a1] = arg;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic reset_core();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_img();
    tb_sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tb_addr  = i[7:0];
      tb_wdata = img[i];
      tb_cs    = 1'b1;
      tb_we    = 1'b1;
      @(negedge clk);
    end
    tb_cs  = 1'b0;
    tb_we  = 1'b0;
    tb_sel = 1'b0;
  endtask

  task automatic ram_read(input logic [7:0] a, output logic [7:0] d);
    tb_sel  = 1'b1;
    tb_addr = a;
    tb_cs   = 1'b1;
    tb_we   = 1'b0;
    @(negedge clk);
    d      = ram_rdata;
    tb_cs  = 1'b0;
    tb_sel = 1'b0;
  endtask

  // Instruction-level reference: executes the image with plain arithmetic,
  // queues every store and totals the documented per-instruction latency.
  task automatic run_model();
    logic [7:0] mpc, mac, x, w0, a1;
    bit         done;
    int         steps;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    q.delete();
    mpc = 8'h00; mac = 8'h00; exp_ill = 1'b0; exp_cyc = 0; done = 1'b0; steps = 0;
    while (!done && steps < 4000) begin
      steps++;
      a1  = mpc + 8'd1;
      w0  = mm[mpc];
      x   = mm[a1];
      mpc = mpc + 8'd2;
      case (w0[7:4])
        4'h0: exp_cyc += 5;
        4'h1: begin mac = mm[x];        exp_cyc += 7; end
        4'h2: begin mm[x] = mac; q.push_back('{addr: x, data: mac}); exp_cyc += 5; end
        4'h3: begin mac = mac + mm[x];  exp_cyc += 7; end
        4'h4: begin mac = mac - mm[x];  exp_cyc += 7; end
        4'h5: begin mac = mac & mm[x];  exp_cyc += 7; end
        4'h6: begin mac = mac | mm[x];  exp_cyc += 7; end
        4'h7: begin done = 1'b1;        exp_cyc += 5; end
        4'h8: begin
          if ((w0[1:0] == 2'd0 && $signed(mac) < 0) ||
              (w0[1:0] == 2'd1 && mac == 8'd0) ||
              (w0[1:0] == 2'd2 && $signed(mac) > 0))
            mpc = mpc + 8'd2;
          exp_cyc += 5;
        end
        4'h9: begin mpc = x;            exp_cyc += 5; end
        4'hA: begin mac = 8'h00;        exp_cyc += 5; end
        4'hB: begin mac = ~mac;         exp_cyc += 5; end
        4'hC: begin mpc = mm[x];        exp_cyc += 7; end
        4'hD: begin
          mm[x] = mpc;
          q.push_back('{addr: x, data: mpc});
          mpc = x + 8'd1;
          exp_cyc += 5;
        end
        default: begin done = 1'b1; exp_ill = 1'b1; exp_cyc += 5; end
      endcase
    end
    exp_pc = mpc;
    exp_ac = mac;
  endtask

  task automatic run_and_check(input string name);
    int n;
    reset_core();
    load_img();
    run_model();
    sb_en = 1'b1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (!halted && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    sb_en = 1'b0;
    check({name, "_halted"}, halted, 1);
    check({name, "_cycles"}, n, exp_cyc);
    check({name, "_pc"}, pc, exp_pc);
    check({name, "_ac"}, ac, exp_ac);
    check({name, "_illegal"}, illegal, exp_ill);
    check({name, "_wr_pending"}, q.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    logic [7:0] skip_ac  [5] = '{8'h80, 8'h80, 8'h01, 8'h00, 8'h01};
    logic [1:0] skip_cnd [5] = '{2'd0,  2'd2,  2'd2,  2'd1,  2'd3};
    logic [7:0] skip_pc  [5] = '{8'h08, 8'h06, 8'h08, 8'h08, 8'h06};
    logic [3:0] rops     [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'hA, 4'hB};

    rst = 1'b1; run = 1'b0;
    tb_sel = 1'b0; tb_cs = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;

    // Reset and idle: no memory strobe while run stays low.
    @(negedge clk);
    check("rst_mem_cs", core_cs, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_cs", core_cs, 0);
    end
    check("idle_pc", pc, 0);
    check("idle_ac", ac, 0);
    check("idle_halted", halted, 0);
    check("idle_illegal", illegal, 0);
    check("idle_mem_addr", core_addr, 0);
    check("idle_mem_we", core_we, 0);
    check("idle_mem_wdata", core_wdata, 0);

    // Fibonacci loop.
    clear_img();
    put(8'h00, 4'h1, 2'd0, 8'h1D); put(8'h02, 4'h3, 2'd0, 8'h1E);
    put(8'h04, 4'h2, 2'd0, 8'h1F); put(8'h06, 4'h1, 2'd0, 8'h1D);
    put(8'h08, 4'h2, 2'd0, 8'h1E); put(8'h0A, 4'h1, 2'd0, 8'h1F);
    put(8'h0C, 4'h2, 2'd0, 8'h1D); put(8'h0E, 4'h1, 2'd0, 8'h20);
    put(8'h10, 4'h4, 2'd0, 8'h21); put(8'h12, 4'h2, 2'd0, 8'h20);
    put(8'h14, 4'h8, 2'd1, 8'h00); put(8'h16, 4'h9, 2'd0, 8'h00);
    put(8'h18, 4'h7, 2'd0, 8'h00);
    img[8'h1C] = 8'h00; img[8'h1D] = 8'h01; img[8'h1E] = 8'h00;
    img[8'h1F] = 8'h00; img[8'h20] = 8'h0A; img[8'h21] = 8'h01;
    run_and_check("fib");
    check("fib_illegal_const", illegal, 0);
    ram_read(8'h1F, d); check("fib_sum", d, 8'h59);
    ram_read(8'h1D, d); check("fib_t1", d, 8'h59);
    ram_read(8'h1E, d); check("fib_t2", d, 8'h37);
    ram_read(8'h20, d); check("fib_ctr", d, 8'h00);

    // Signed skip conditions.
    for (int i = 0; i < 5; i++) begin
      clear_img();
      put(8'h00, 4'h1, 2'd0, 8'h80);
      put(8'h02, 4'h8, skip_cnd[i], 8'h00);
      put(8'h04, 4'h7, 2'd0, 8'h00);
      put(8'h06, 4'h7, 2'd0, 8'h00);
      img[8'h80] = skip_ac[i];
      run_and_check("skip");
      check("skip_pc_const", pc, skip_pc[i]);
    end

    // Subroutine call and return.
    clear_img();
    put(8'h00, 4'h9, 2'd0, 8'h10);
    put(8'h10, 4'hD, 2'd0, 8'h40);
    put(8'h12, 4'h7, 2'd0, 8'h00);
    put(8'h41, 4'hB, 2'd0, 8'h00);
    put(8'h43, 4'hC, 2'd0, 8'h40);
    run_and_check("jns");
    check("jns_pc_const", pc, 8'h14);
    check("jns_ac_const", ac, 8'hFF);
    ram_read(8'h40, d); check("jns_ret_addr", d, 8'h12);

    // Illegal opcode.
    clear_img();
    put(8'h00, 4'hA, 2'd0, 8'h00);
    put(8'h02, 4'hE, 2'd0, 8'h00);
    run_and_check("illegal");
    check("illegal_flag_const", illegal, 1);
    check("illegal_pc_const", pc, 8'h04);

    // Arithmetic wrap, then store followed by load of the same address.
    clear_img();
    put(8'h00, 4'h1, 2'd0, 8'h80); put(8'h02, 4'h3, 2'd0, 8'h81);
    put(8'h04, 4'h2, 2'd0, 8'h82); put(8'h06, 4'h1, 2'd0, 8'h80);
    put(8'h08, 4'h1, 2'd0, 8'h82); put(8'h0A, 4'h7, 2'd0, 8'h00);
    img[8'h80] = 8'hFF; img[8'h81] = 8'h01; img[8'h82] = 8'h77;
    run_and_check("wrap");
    check("wrap_ac_const", ac, 8'h00);

    // SKIP at the top of the address space wraps PC through zero.
    clear_img();
    put(8'h00, 4'h9, 2'd0, 8'hFC);
    put(8'hFC, 4'hA, 2'd0, 8'h00);
    put(8'hFE, 4'h8, 2'd1, 8'h00);
    put(8'h02, 4'h7, 2'd0, 8'h00);
    run_and_check("skipwrap");
    check("skipwrap_pc_const", pc, 8'h04);

    // Randomised straight-line programs.
    for (int r = 0; r < 8; r++) begin
      clear_img();
      for (int a = 8'h80; a < 8'h90; a++) img[a] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 12; k++) begin
        logic [3:0] op;
        op = rops[$urandom_range(0, 9)];
        if ($urandom_range(0, 39) == 0) op = 4'hE | 4'($urandom_range(0, 1));
        put(8'(2 * k), op, 2'($urandom_range(0, 3)), 8'(8'h80 + $urandom_range(0, 15)));
      end
      put(8'h18, 4'h7, 2'd0, 8'h00);
      put(8'h1A, 4'h7, 2'd0, 8'h00);
      run_and_check("rand");
    end

    // Reset asserted during the EX0 of a STORE.
    clear_img();
    put(8'h00, 4'h1, 2'd0, 8'h80);
    put(8'h02, 4'h2, 2'd0, 8'h81);
    put(8'h04, 4'h7, 2'd0, 8'h00);
    img[8'h80] = 8'h5A; img[8'h81] = 8'h33;
    reset_core();
    load_img();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (!core_we && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_store_we_seen", core_we, 1);
    rst = 1'b1;
    #1;
    check("mid_store_we_gated", core_we, 0);
    check("mid_store_cs_gated", core_cs, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_store_pc", pc, 0);
    check("mid_store_ac", ac, 0);
    check("mid_store_halted", halted, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_store_idle_cs", core_cs, 0);
    end
    ram_read(8'h81, d);
    check("mid_store_mem", d, 8'h33);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (!halted && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("restart_halted", halted, 1);
    check("restart_ac", ac, 8'h5A);
    check("restart_pc", pc, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
